// File: rtl/ev_reg_block.sv
// ev_reg_block -- bus-facing register block for the event monitor.
//
// Holds the monitor configuration (enable, arm, per-channel trigger setup),
// exposes FIFO/trigger status, and gives software a pop-on-read window onto
// the event FIFO: reading EVT_PROBE pops one event and latches the whole
// record so the ID and timestamp can be read afterwards without popping again.
//
// Build option: define EVMON_IRQ_EN to include IRQ_CTRL, FIFO fill-threshold
// detection (STATUS[19]) and the level interrupt. Without it, irq is tied low,
// IRQ_CTRL reads 0 and STATUS[19] reads 0.

module ev_reg_block #(
  parameter int PROBE_W    = 32,
  parameter int ID_W       = 8,
  parameter int TS_W       = 48,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_TRIG   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 bus_wr,
  input  logic                                 bus_rd,
  input  logic [7:0]                           bus_addr,
  input  logic [31:0]                          bus_wdata,
  output logic [31:0]                          bus_rdata,
  output logic                                 bus_rvalid,
  output logic                                 en,
  output logic                                 arm,
  output logic [2*NUM_TRIG-1:0]                trig_mode,
  output logic [PROBE_W*NUM_TRIG-1:0]          trig_value,
  output logic [PROBE_W*NUM_TRIG-1:0]          trig_mask,
  output logic                                 trig_combine,
  output logic                                 clear_sticky,
  output logic                                 evt_pop,
  input  logic [TS_W+ID_W+PROBE_W-1:0]         evt_data,
  input  logic                                 evt_valid,
  input  logic                                 fifo_empty,
  input  logic                                 fifo_full,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  input  logic                                 triggered_sticky,
  input  logic                                 fifo_overflow_sticky,
  output logic                                 irq
);

  localparam int EVT_W = TS_W + ID_W + PROBE_W;

  localparam logic [7:0] A_CONTROL   = 8'h00;
  localparam logic [7:0] A_STATUS    = 8'h04;
  localparam logic [7:0] A_IRQ_CTRL  = 8'h08;
  localparam logic [7:0] A_EVT_PROBE = 8'h10;
  localparam logic [7:0] A_EVT_ID    = 8'h14;
  localparam logic [7:0] A_EVT_TS_LO = 8'h18;
  localparam logic [7:0] A_EVT_TS_HI = 8'h1C;

  // Trigger channel i occupies a value/mask pair starting at 0x20 + 8*i.
  function automatic logic [7:0] trig_value_addr(input int ch);
    return 8'(32 + 8 * ch);
  endfunction

  function automatic logic [7:0] trig_mask_addr(input int ch);
    return 8'(36 + 8 * ch);
  endfunction

  logic             wr_control;
  logic             wr_status;
  logic             rd_probe;
  logic             pop_req;
  logic             underflow_set;

  logic [EVT_W-1:0] snap;
  logic             snap_valid;
  logic             underflow;
  logic             thresh_hit;

  logic [31:0]      snap_probe32;
  logic [31:0]      snap_id32;
  logic [63:0]      snap_ts64;
  logic [31:0]      live_probe32;
  logic [31:0]      control_rd;
  logic [31:0]      status_rd;
  logic [31:0]      irq_ctrl_rd;
  logic [31:0]      rd_mux;

  assign wr_control    = bus_wr && (bus_addr == A_CONTROL);
  assign wr_status     = bus_wr && (bus_addr == A_STATUS);
  assign rd_probe      = bus_rd && (bus_addr == A_EVT_PROBE);
  assign pop_req       = rd_probe && evt_valid;
  assign underflow_set = rd_probe && !evt_valid;

  // The pop strobe is combinational so the FIFO advances on the same edge the
  // probe word is captured; gating with rst_n keeps it quiet while in reset.
  assign evt_pop = pop_req && rst_n;

  // Field views of the latched record and the live FIFO head, zero-extended.
  assign snap_probe32 = 32'(snap[PROBE_W-1:0]);
  assign snap_id32    = 32'(snap[PROBE_W +: ID_W]);
  assign snap_ts64    = 64'(snap[PROBE_W+ID_W +: TS_W]);
  assign live_probe32 = 32'(evt_data[PROBE_W-1:0]);

  // CONTROL, trigger value and trigger mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      arm          <= 1'b0;
      trig_combine <= 1'b0;
      trig_mode    <= '0;
      trig_value   <= '0;
      trig_mask    <= '0;
    end else begin
      if (wr_control) begin
        en           <= bus_wdata[0];
        arm          <= bus_wdata[1];
        trig_combine <= bus_wdata[8];
        trig_mode    <= bus_wdata[16 +: 2*NUM_TRIG];
      end
      if (bus_wr) begin
        for (int i = 0; i < NUM_TRIG; i++) begin
          if (bus_addr == trig_value_addr(i)) begin
            trig_value[i*PROBE_W +: PROBE_W] <= bus_wdata[PROBE_W-1:0];
          end
          if (bus_addr == trig_mask_addr(i)) begin
            trig_mask[i*PROBE_W +: PROBE_W] <= bus_wdata[PROBE_W-1:0];
          end
        end
      end
    end
  end

  // One-cycle clear_sticky pulse following a CONTROL write with bit 3 set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_sticky <= 1'b0;
    end else begin
      clear_sticky <= wr_control && bus_wdata[3];
    end
  end

  // Event snapshot, its valid flag and the underflow sticky (set beats W1C).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (pop_req) begin
        snap       <= evt_data;
        snap_valid <= 1'b1;
      end else if (underflow_set) begin
        snap_valid <= 1'b0;
      end

      if (wr_status && bus_wdata[18]) begin
        underflow <= 1'b0;
      end
      if (underflow_set) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef EVMON_IRQ_EN
  logic       wr_irq_ctrl;
  logic       thresh_irq_en;
  logic       ovf_irq_en;
  logic [7:0] threshold;
  logic       thresh_cond;
  logic       thresh_cond_q;
  logic       thresh_set;

  assign wr_irq_ctrl = bus_wr && (bus_addr == A_IRQ_CTRL);
  assign thresh_cond = (threshold != 8'd0) && (8'(fifo_count) >= threshold);
  assign thresh_set  = thresh_cond && !thresh_cond_q;
  assign irq_ctrl_rd = {16'd0, threshold, 6'd0, ovf_irq_en, thresh_irq_en};

  // IRQ_CTRL register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_irq_en <= 1'b0;
      ovf_irq_en    <= 1'b0;
      threshold     <= 8'd0;
    end else if (wr_irq_ctrl) begin
      thresh_irq_en <= bus_wdata[0];
      ovf_irq_en    <= bus_wdata[1];
      threshold     <= bus_wdata[15:8];
    end
  end

  // Threshold edge detector; only a fresh crossing sets the sticky, and a
  // crossing in the same cycle as the W1C keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_cond_q <= 1'b0;
      thresh_hit    <= 1'b0;
    end else begin
      thresh_cond_q <= thresh_cond;
      if (wr_status && bus_wdata[19]) begin
        thresh_hit <= 1'b0;
      end
      if (thresh_set) begin
        thresh_hit <= 1'b1;
      end
    end
  end

  // Registered level interrupt from the enabled sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= (thresh_hit && thresh_irq_en) || (fifo_overflow_sticky && ovf_irq_en);
    end
  end
`else
  assign thresh_hit  = 1'b0;
  assign irq_ctrl_rd = 32'd0;
  assign irq         = 1'b0;
`endif

  // Readback images of the composite registers.
  always_comb begin
    control_rd                        = 32'd0;
    control_rd[0]                     = en;
    control_rd[1]                     = arm;
    control_rd[8]                     = trig_combine;
    control_rd[16 +: 2*NUM_TRIG]      = trig_mode;

    status_rd                         = 32'd0;
    status_rd[0]                      = fifo_empty;
    status_rd[1]                      = fifo_full;
    status_rd[2]                      = snap_valid;
    status_rd[15:8]                   = 8'(fifo_count);
    status_rd[16]                     = triggered_sticky;
    status_rd[17]                     = fifo_overflow_sticky;
    status_rd[18]                     = underflow;
    status_rd[19]                     = thresh_hit;
  end

  // Read address decode; all sources are pre-edge register values, so a
  // write in the same cycle never leaks into the returned data.
  always_comb begin
    rd_mux = 32'd0;
    case (bus_addr)
      A_CONTROL:   rd_mux = control_rd;
      A_STATUS:    rd_mux = status_rd;
      A_IRQ_CTRL:  rd_mux = irq_ctrl_rd;
      A_EVT_PROBE: rd_mux = evt_valid ? live_probe32 : 32'd0;
      A_EVT_ID:    rd_mux = snap_id32;
      A_EVT_TS_LO: rd_mux = snap_ts64[31:0];
      A_EVT_TS_HI: rd_mux = snap_ts64[63:32];
      default: begin
        for (int i = 0; i < NUM_TRIG; i++) begin
          if (bus_addr == trig_value_addr(i)) begin
            rd_mux = 32'(trig_value[i*PROBE_W +: PROBE_W]);
          end
          if (bus_addr == trig_mask_addr(i)) begin
            rd_mux = 32'(trig_mask[i*PROBE_W +: PROBE_W]);
          end
        end
      end
    endcase
  end

  // Registered read return; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata  <= 32'd0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_rd;
      if (bus_rd) begin
        bus_rdata <= rd_mux;
      end
    end
  end

  // The latched probe word is kept for completeness of the record; software
  // receives the probe from the live read, so it is not otherwise observed.
  logic unused_snap_probe;
  assign unused_snap_probe = ^snap_probe32;

endmodule

// File: doc/ev_reg_block.md
EV_REG_BLOCK -- requirements
Module: ev_reg_block

Interface
REQ-001 Parameter PROBE_W, default 32, probe width (1..32).
REQ-002 Parameter ID_W, default 8, event ID width (1..32).
REQ-003 Parameter TS_W, default 48, timestamp width (1..64).
REQ-004 Parameter FIFO_DEPTH, default 16, event FIFO depth (2..255).
REQ-005 Parameter NUM_TRIG, default 2, trigger channel count (1..4).
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 bus_wr, bus_rd  in  1 each  single-cycle write / read strobes.
REQ-009 bus_addr  in  8; bus_wdata  in  32  byte address and write data.
REQ-010 bus_rdata  out  32; bus_rvalid  out  1  registered read data and its valid.
REQ-011 en, arm  out  1 each  monitor enable, trigger arm.
REQ-012 trig_mode  out  2*NUM_TRIG; trig_value, trig_mask  out  PROBE_W*NUM_TRIG  per-channel trigger config, channel i at slice i.
REQ-013 trig_combine  out  1  0 = OR of channel hits, 1 = AND.
REQ-014 clear_sticky  out  1  one-cycle pulse.
REQ-015 evt_pop  out  1; evt_data  in  TS_W+ID_W+PROBE_W {ts,id,probe}; evt_valid  in  1.
REQ-016 fifo_empty, fifo_full  in  1; fifo_count  in  $clog2(FIFO_DEPTH+1).
REQ-017 triggered_sticky, fifo_overflow_sticky  in  1 each.
REQ-018 irq  out  1  level interrupt.

Function
REQ-019 Map: 0x00 CONTROL, 0x04 STATUS, 0x08 IRQ_CTRL, 0x10 EVT_PROBE, 0x14 EVT_ID, 0x18 EVT_TS_LO, 0x1C EVT_TS_HI, 0x20+8i TRIG_VALUE[i], 0x24+8i TRIG_MASK[i]; unmapped/unused-channel reads return 0, writes ignored.
REQ-020 CONTROL: [0] en, [1] arm, [3] clear_sticky (write-only, reads 0), [8] trig_combine, [16+2i+:2] trig_mode[i]; unused bits read 0.
REQ-021 clear_sticky SHALL pulse exactly one cycle after a CONTROL write with wdata[3]=1 (registered).
REQ-022 Read latency: bus_rdata/bus_rvalid valid exactly one cycle after bus_rd, bus_rvalid=1 for one cycle; bus_rdata holds last value otherwise.
REQ-023 Read of EVT_PROBE with evt_valid=1: evt_pop pulses combinationally that cycle, full evt_data captured into snapshot register, snap_valid set; returned data = probe zero-extended.
REQ-024 EVT_ID, EVT_TS_LO, EVT_TS_HI return snapshot fields (id zero-extended; ts[31:0]; ts[TS_W-1:32] zero-extended, 0 if TS_W<=32) with no pop.
REQ-025 Read of EVT_PROBE with evt_valid=0: no pop, returns 0, snapshot retained, snap_valid cleared, underflow sticky set.
REQ-026 STATUS: [0] fifo_empty, [1] fifo_full, [2] snap_valid, [15:8] fifo_count zero-extended, [16] triggered_sticky, [17] fifo_overflow_sticky, [18] underflow, [19] thresh_hit.
REQ-027 STATUS bits 18/19 SHALL be write-1-to-clear; a set event in the same cycle as clear wins.
REQ-028 Simultaneous bus_wr and bus_rd: read returns pre-write register value.
REQ-029 thresh_hit sets on rising transition of (fifo_count >= IRQ_CTRL[15:8]) when threshold nonzero.

Reset
REQ-030 rst_n low: all config registers, snapshot, snap_valid, stickies, bus_rdata, bus_rvalid, clear_sticky, irq = 0 immediately.
REQ-031 A read in flight at reset assertion SHALL produce no bus_rvalid after release.

Configuration
REQ-032 Macro EVMON_IRQ_EN defined: IRQ_CTRL = [0] thresh_irq_en, [1] ovf_irq_en, [15:8] threshold; irq registered = (thresh_hit&[0]) | (fifo_overflow_sticky&[1]).
REQ-033 Macro undefined: irq tied 0, IRQ_CTRL reads 0 and ignores writes, STATUS[19] reads 0.

Verification
REQ-034 Write 0x00=0x0005_0103 -> en=1, arm=1, trig_combine=1, trig_mode[0]=1, trig_mode[1]=1; readback 0x0005_0103.
REQ-035 evt_valid=1, evt_data={ts=0x12_3456789A, id=0x5A, probe=0xDEADBEEF}; read 0x10,0x14,0x18,0x1C -> 0xDEADBEEF, 0x5A, 0x3456789A, 0x12; one evt_pop total.
REQ-036 Read 0x10 with evt_valid=0 -> rdata 0, no pop, STATUS[18]=1; write 0x04=0x0004_0000 -> STATUS[18]=0.
REQ-037 EVMON_IRQ_EN, IRQ_CTRL=0x0401, fifo_count 3->4 -> STATUS[19]=1, irq=1 next cycle; W1C bit 19 -> irq=0.
REQ-038 Write 0x00 bit3 -> clear_sticky high exactly one cycle; CONTROL readback bit3=0.
REQ-039 Assert rst_n low mid-read -> all outputs 0 asynchronously, no bus_rvalid after release.
